stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
- Control FSM for the stopwatch: drives the counter's 2-bit `en` interface from two raw push-buttons (start/stop, lap/clear).
- Debounces both buttons and edge-detects presses.
- Sequences IDLE/RUN/LAP/STOP and produces the counter-enable code plus display-side strobes.
- Sits between the board buttons and the second counter / display latch.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive identical raw samples required before a button's debounced level changes; legal range is at least 2. Board builds override with about 1,000,000.
- CNT_W, 20, width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- btn_start  input  1  raw start/stop button, active-high, may bounce
- btn_lap  input  1  raw lap/clear button, active-high, may bounce
- en  output  2  counter enable code: 00 CLEAR, 01 RUN, 10 RUN_LAP, 11 HOLD
- lap_capture  output  1  one-cycle pulse on entry to LAP; display latches count
- running  output  1  high while en is 01 or 10
- state_o  output  2  current state: 00 IDLE, 01 RUN, 10 LAP, 11 STOP

Behaviour:
- Reset values (asynchronous): state IDLE, en=00, lap_capture=0, running=0, state_o=00, debounced levels 0, debounce counters 0, edge-detect registers 0.
- Debounce, per button, independent:
  - If sample != debounced level, the counter increments; otherwise it clears to 0.
  - When counter == DEBOUNCE_CYCLES-1 and the sample still differs: debounced level <= sample, counter <= 0.
  - Any matching sample before that point restarts the count, so glitches shorter than DEBOUNCE_CYCLES samples are ignored.
- Press detect: press = debounced & ~debounced_d, where debounced_d is the level registered one cycle earlier. Releases cause no action.
- Latency: edge 1 is the first edge sampling the raw button high. The debounced level rises at edge DEBOUNCE_CYCLES, and the state/en update at edge DEBOUNCE_CYCLES+1.
- FSM transitions (sp = start press, lp = lap press):
  - IDLE: sp -> RUN; lp -> IDLE (no-op).
  - RUN: sp -> STOP; lp -> LAP.
  - LAP: sp -> STOP; lp -> RUN (display released).
  - STOP: sp -> RUN (resume, count kept); lp -> IDLE (clear).
- Simultaneous sp and lp in the same cycle: sp wins, lp is discarded (not queued).
- Outputs are registered and decoded from the state: IDLE->00, RUN->01, LAP->10, STOP->11. `en` therefore changes in the same cycle as `state_o`.
- lap_capture is high exactly in the first cycle the state is LAP. Re-entering LAP later pulses it again.
- A button held through reset deassertion is seen as a fresh press after DEBOUNCE_CYCLES+1 edges; this is intended.
- Reset asserted mid-debounce or mid-state aborts everything; no pending press survives.

Optional Feature:
- Macro STOPWATCH_CTRL_BTN_SYNC_EN.
- Defined: each raw button passes through a 2-flop synchronizer (reset to 0) before the debouncer; end-to-end latency becomes DEBOUNCE_CYCLES+3 edges.
- Undefined: raw inputs feed the debouncer directly (inputs are assumed already synchronous); latency is DEBOUNCE_CYCLES+1 edges.
- FSM behaviour is otherwise identical.

Test Plan:
- Release reset, btn_start held high 40 cycles (DEBOUNCE_CYCLES=16) -> en 00->01 at edge 17 after first high sample, running=1, state_o=01; no further change while held.
- btn_start pulses high 15 cycles, low 3, high 15 -> no state change, en stays 00.
- From RUN, lap press -> en=10, lap_capture=1 for exactly one cycle, state_o=10; second lap press -> en=01, no lap_capture.
- RUN, start press -> en=11; start press -> en=01; start press -> en=11; lap press -> en=00, running=0.
- In RUN, raise btn_start and btn_lap on the same edge for 20 cycles -> state STOP (en=11), no LAP entry, no lap_capture.
- Assert reset 3 cycles while in LAP with btn_lap bouncing -> en=00, state_o=00, lap_capture=0 immediately. Repeat the first scenario with STOPWATCH_CTRL_BTN_SYNC_EN defined -> transition at edge 19.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: debounced two-button IDLE/RUN/LAP/STOP control for the second counter; STOPWATCH_CTRL_BTN_SYNC_EN adds input synchronizers
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_lap,
  output logic [1:0] en,
  output logic       lap_capture,
  output logic       running,
  output logic [1:0] state_o
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, LAP = 2'b10, STOP = 2'b11} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  state_t state, state_nx;
  logic [1:0] raw, smp, db, db_d, press;
  logic [CNT_W-1:0] cnt [2];
  assign raw = {btn_lap, btn_start};
`ifdef STOPWATCH_CTRL_BTN_SYNC_EN
  logic [1:0] s1, s2;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  assign smp = s2;
`else
  assign smp = raw;
`endif
  // a sample matching the current level restarts the count, so short glitches never flip it
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      db <= '0;
      db_d <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      db_d <= db;
      for (int i = 0; i < 2; i++)
        if (smp[i] == db[i]) cnt[i] <= '0;
        else if (cnt[i] == LAST) begin
          db[i] <= smp[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 1'b1;
    end
  assign press = db & ~db_d;
  // start press outranks a lap press in the same cycle; the lap press is dropped
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = press[0] ? RUN : IDLE;
      RUN:     state_nx = press[0] ? STOP : press[1] ? LAP : RUN;
      LAP:     state_nx = press[0] ? STOP : press[1] ? RUN : LAP;
      default: state_nx = press[0] ? RUN : press[1] ? IDLE : STOP;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      lap_capture <= 1'b0;
      running <= 1'b0;
    end else begin
      state <= state_nx;
      lap_capture <= state_nx == LAP && state != LAP;
      running <= state_nx == RUN || state_nx == LAP;
    end
  assign en = state;
  assign state_o = state;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: table vectors, hand sequences and random stimulus against a window-based reference model
module tb_stopwatch_ctrl;
  localparam int D = 16;
`ifdef STOPWATCH_CTRL_BTN_SYNC_EN
  localparam int SD = 2;
`else
  localparam int SD = 0;
`endif
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_LAP = 2'd2, S_STOP = 2'd3;
  logic clk, reset, btn_start, btn_lap, lap_capture, running;
  logic [1:0] en, state_o;
  int vectors = 0, errors = 0, caps = 0;
  stopwatch_ctrl dut (
    .clk(clk), .reset(reset), .btn_start(btn_start), .btn_lap(btn_lap),
    .en(en), .lap_capture(lap_capture), .running(running), .state_o(state_o)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] mst;
  bit mcap;
  bit [1:0] mdb, mdbd, p1, p2;
  logic [D-1:0] hist [2];
  task automatic model_reset();
    mst = S_IDLE;
    mcap = 1'b0;
    mdb = '0;
    mdbd = '0;
    p1 = '0;
    p2 = '0;
    hist[0] = '0;
    hist[1] = '0;
  endtask
  task automatic model_step(bit [1:0] r);
    bit [1:0] smp;
    bit sp, lp;
    logic [1:0] old;
    smp = (SD == 2) ? p2 : r;
    p2 = p1;
    p1 = r;
    sp = mdb[0] && !mdbd[0];
    lp = mdb[1] && !mdbd[1];
    old = mst;
    if (sp) mst = (old == S_RUN || old == S_LAP) ? S_STOP : S_RUN;
    else if (lp) mst = (old == S_RUN) ? S_LAP : (old == S_LAP) ? S_RUN : S_IDLE;
    mcap = mst == S_LAP && old != S_LAP;
    mdbd = mdb;
    for (int i = 0; i < 2; i++) begin
      hist[i] = {hist[i][D-2:0], smp[i]};
      if (hist[i] == {D{!mdb[i]}}) mdb[i] = !mdb[i];
    end
  endtask
  task automatic check(string name, int got, int exp);
    vectors++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  task automatic tick(bit s, bit l);
    btn_start = s;
    btn_lap = l;
    @(posedge clk);
    model_step({l, s});
    #1;
    check("model {state_o,en,running,lap_capture}", 32'({state_o, en, running, lap_capture}),
          32'({mst, mst, mst == S_RUN || mst == S_LAP, mcap}));
    caps += int'(lap_capture);
  endtask
  typedef struct { bit s; bit l; int n; logic [1:0] st; int c; } vec_t;
  vec_t tbl [$];
  function automatic vec_t mk(bit s, bit l, int n, logic [1:0] st, int c);
    vec_t v;
    v.s = s; v.l = l; v.n = n; v.st = st; v.c = c;
    return v;
  endfunction
  initial begin
    tbl.push_back(mk(1, 0, 20, S_RUN, 0));
    tbl.push_back(mk(0, 0, 20, S_RUN, 0));
    tbl.push_back(mk(0, 1, 20, S_LAP, 1));
    tbl.push_back(mk(0, 0, 20, S_LAP, 0));
    tbl.push_back(mk(0, 1, 20, S_RUN, 0));
    tbl.push_back(mk(0, 0, 20, S_RUN, 0));
    tbl.push_back(mk(1, 0, 20, S_STOP, 0));
    tbl.push_back(mk(0, 0, 20, S_STOP, 0));
    tbl.push_back(mk(1, 0, 20, S_RUN, 0));
    tbl.push_back(mk(0, 0, 20, S_RUN, 0));
    tbl.push_back(mk(1, 0, 20, S_STOP, 0));
    tbl.push_back(mk(0, 0, 20, S_STOP, 0));
    tbl.push_back(mk(0, 1, 20, S_IDLE, 0));
    tbl.push_back(mk(0, 0, 20, S_IDLE, 0));
    tbl.push_back(mk(0, 1, 20, S_IDLE, 0));
    tbl.push_back(mk(0, 0, 20, S_IDLE, 0));
    tbl.push_back(mk(1, 0, 15, S_IDLE, 0));
    tbl.push_back(mk(0, 0, 3, S_IDLE, 0));
    tbl.push_back(mk(1, 0, 15, S_IDLE, 0));
    tbl.push_back(mk(0, 0, 20, S_IDLE, 0));
    tbl.push_back(mk(1, 0, 20, S_RUN, 0));
    tbl.push_back(mk(0, 0, 20, S_RUN, 0));
    tbl.push_back(mk(1, 1, 20, S_STOP, 0));
    tbl.push_back(mk(0, 0, 20, S_STOP, 0));
    tbl.push_back(mk(1, 0, 20, S_RUN, 0));
    tbl.push_back(mk(0, 0, 20, S_RUN, 0));
    tbl.push_back(mk(0, 1, 20, S_LAP, 1));
    tbl.push_back(mk(0, 0, 20, S_LAP, 0));
    reset = 1'b1;
    btn_start = 1'b0;
    btn_lap = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 32'({state_o, en, running, lap_capture}), 0);
    reset = 1'b0;
    for (int e = 1; e <= D + 1 + SD; e++) begin
      tick(1, 0);
      if (e == D + SD) check("latency_before", 32'(state_o), 0);
    end
    check("latency_state", 32'(state_o), 1);
    check("latency_en", 32'(en), 1);
    check("latency_running", 32'(running), 1);
    foreach (tbl[k]) begin
      caps = 0;
      for (int j = 0; j < tbl[k].n; j++) tick(tbl[k].s, tbl[k].l);
      check($sformatf("row%0d state/en/running", k), 32'({state_o, en, running}),
            32'({tbl[k].st, tbl[k].st, tbl[k].st == S_RUN || tbl[k].st == S_LAP}));
      check($sformatf("row%0d lap_capture count", k), caps, tbl[k].c);
    end
    tick(0, 1);
    tick(0, 0);
    tick(0, 1);
    reset = 1'b1;
    #1;
    check("reset_mid_async", 32'({state_o, en, running, lap_capture}), 0);
    repeat (3) begin
      btn_lap = ~btn_lap;
      @(posedge clk);
      #1;
    end
    check("reset_mid_held", 32'({state_o, en, running, lap_capture}), 0);
    reset = 1'b0;
    model_reset();
    repeat (250) begin
      bit s, l;
      int n;
      s = 1'($urandom_range(0, 1));
      l = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 40);
      repeat (n) tick(s, l);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
